vga_timing_gen: RTL

Parametrised raster timing generator for the VGA output path. It holds the horizontal and vertical pixel counters as one unit, which retires the standalone vertical counter and its external enable wiring. From those counters it produces hsync, vsync, a visible-area flag, line/frame strobes and a frame counter. It sits between the 25 MHz pixel clock domain and the pixel/colour generation logic, and the timing mode is set by parameters.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/timing_axis_counter.sv | 36 +++
 rtl/vga_timing_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants, derived-total helpers and registered flag payload.
// Defaults describe 640x480@60 on a 25 MHz pixel clock.
package vga_timing_pkg;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam bit          DEF_HS_POL    = SYNC_ACTIVE_LOW;
  localparam bit          DEF_VS_POL    = SYNC_ACTIVE_LOW;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_FRAME_W   = 8;

  // Flags decoded from the counts and held for one pixel clock.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } raster_flags_t;

  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return visible + front + sync + back;
  endfunction

  // True when a W-bit counter can represent 0..total-1.
  function automatic bit fits_width(input int unsigned total, input int unsigned w);
    if (w >= 32) return 1'b1;
    return total <= (32'd1 << w);
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// Wrapping raster axis counter; advances on tick and flags the last position.
module timing_axis_counter #(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (tick) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = tick && (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V counters, registered sync/visible decode,
// combinational line/frame strobes and a completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          HS_POL    = DEF_HS_POL,
  parameter bit          VS_POL    = DEF_VS_POL,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned FRAME_W   = DEF_FRAME_W
) (
  input  logic               clk_25Mhz,
  input  logic               reset,
  input  logic               enable,
  output logic [CNT_W-1:0]   H_Count_Value,
  output logic [CNT_W-1:0]   V_Count_Value,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_end,
  output logic               frame_end,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL  = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL  = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

  localparam raster_flags_t FLAGS_RST = '{hsync: ~HS_POL, vsync: ~VS_POL, video_on: 1'b0};

  if (H_SYNC < 1 || V_SYNC < 1 || !fits_width(H_TOTAL, CNT_W) || !fits_width(V_TOTAL, CNT_W))
  begin : g_param_check
    $error("vga_timing_gen: sync width must be >= 1 and CNT_W must hold H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               h_wrap;
  logic               v_wrap;
  logic               h_in_sync;
  logic               v_in_sync;
  raster_flags_t      flags_q;
  raster_flags_t      flags_d;
  logic [FRAME_W-1:0] frame_count_q;
  logic [FRAME_W-1:0] frame_count_d;

  // V advances on the H wrap, so its wrap is the end-of-frame strobe.
  timing_axis_counter #(.TOTAL(H_TOTAL), .W(CNT_W)) u_h_axis (
    .clk   (clk_25Mhz),
    .reset (reset),
    .tick  (enable),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  timing_axis_counter #(.TOTAL(V_TOTAL), .W(CNT_W)) u_v_axis (
    .clk   (clk_25Mhz),
    .reset (reset),
    .tick  (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  // Decode is taken from the current counts every clock, independent of enable.
  always_comb begin
    flags_d       = FLAGS_RST;
    frame_count_d = frame_count_q;

    h_in_sync = (h_cnt >= CNT_W'(HS_FIRST)) && (h_cnt <= CNT_W'(HS_LAST));
    v_in_sync = (v_cnt >= CNT_W'(VS_FIRST)) && (v_cnt <= CNT_W'(VS_LAST));

    flags_d.hsync    = h_in_sync ? HS_POL : ~HS_POL;
    flags_d.vsync    = v_in_sync ? VS_POL : ~VS_POL;
    flags_d.video_on = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));

    if (v_wrap) begin
      frame_count_d = frame_count_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk_25Mhz or posedge reset) begin
    if (reset) begin
      flags_q       <= FLAGS_RST;
      frame_count_q <= '0;
    end else begin
      flags_q       <= flags_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign H_Count_Value = h_cnt;
  assign V_Count_Value = v_cnt;
  assign hsync         = flags_q.hsync;
  assign vsync         = flags_q.vsync;
  assign video_on      = flags_q.video_on;
  assign line_end      = h_wrap;
  assign frame_end     = v_wrap;
  assign frame_count   = frame_count_q;

endmodule
